// File: rtl/router_pkg.sv
// Shared types and header layout for the 1x3 router ingress stage.
package router_pkg;

    localparam int         NUM_PORTS    = 3;
    localparam logic [1:0] ADDR_INVALID = 2'b11;
    localparam int         LEN_MSB      = 7;
    localparam int         LEN_LSB      = 2;

    typedef enum logic [2:0] {
        DECODE,
        WAIT_EMPTY,
        LOAD_FIRST,
        LOAD_DATA,
        FULL_HOLD,
        LOAD_AFTER_FULL,
        CHECK_PARITY,
        DROP
    } state_t;

endpackage

// File: rtl/router_ingress_fsm.sv
// Ingress control: state register, next-state logic and decoded busy/lfd/load strobes.
module router_ingress_fsm
    import router_pkg::*;
(
    input  logic                 clock,
    input  logic                 resetn,
    input  logic                 pkt_valid,
    input  logic [LEN_LSB-1:0]   hdr_addr,
    input  logic [LEN_LSB-1:0]   addr,
    input  logic [NUM_PORTS-1:0] fifo_full,
    input  logic [NUM_PORTS-1:0] fifo_empty,
    input  logic [NUM_PORTS-1:0] soft_reset,
    input  logic                 hold_is_parity,
    output state_t               state,
    output logic                 busy,
    output logic                 lfd_state,
    output logic                 write,
    output logic                 load_hdr,
    output logic                 load_payload,
    output logic                 load_parity,
    output logic                 load_hold,
    output logic                 check_parity
);

    state_t     next_state;
    logic [3:0] full_x;
    logic [3:0] empty_x;
    logic [3:0] sr_x;
    logic       full_sel;
    logic       empty_sel;
    logic       hdr_empty;
    logic       abort;

    // Pad the per-port flags to the full address range so address 3 indexes a zero.
    assign full_x    = {{(4-NUM_PORTS){1'b0}}, fifo_full};
    assign empty_x   = {{(4-NUM_PORTS){1'b0}}, fifo_empty};
    assign sr_x      = {{(4-NUM_PORTS){1'b0}}, soft_reset};
    assign full_sel  = full_x[addr];
    assign empty_sel = empty_x[addr];
    assign hdr_empty = empty_x[hdr_addr];
    assign abort     = sr_x[addr] && (state != DECODE) && (state != DROP);

    always_ff @(posedge clock) begin
        if (!resetn) state <= DECODE;
        else         state <= next_state;
    end

    always_comb begin
        next_state   = state;
        busy         = 1'b0;
        lfd_state    = 1'b0;
        write        = 1'b0;
        load_hdr     = 1'b0;
        load_payload = 1'b0;
        load_parity  = 1'b0;
        load_hold    = 1'b0;
        check_parity = 1'b0;
        case (state)
            DECODE: begin
                if (pkt_valid) begin
                    load_hdr = 1'b1;
                    if (hdr_addr == ADDR_INVALID) next_state = DROP;
                    else if (hdr_empty)           next_state = LOAD_FIRST;
                    else                          next_state = WAIT_EMPTY;
                end
            end
            WAIT_EMPTY: begin
                busy = 1'b1;
                if (empty_sel) next_state = LOAD_FIRST;
            end
            LOAD_FIRST: begin
                busy       = 1'b1;
                write      = 1'b1;
                lfd_state  = 1'b1;
                next_state = LOAD_DATA;
            end
            LOAD_DATA: begin
                write        = !full_sel;
                load_payload = pkt_valid;
                load_parity  = !pkt_valid;
                load_hold    = full_sel;
                if (full_sel)        next_state = FULL_HOLD;
                else if (!pkt_valid) next_state = CHECK_PARITY;
            end
            FULL_HOLD: begin
                busy = 1'b1;
                if (!full_sel) next_state = LOAD_AFTER_FULL;
            end
            LOAD_AFTER_FULL: begin
                busy       = 1'b1;
                write      = 1'b1;
                next_state = hold_is_parity ? CHECK_PARITY : LOAD_DATA;
            end
            CHECK_PARITY: begin
                busy         = 1'b1;
                check_parity = 1'b1;
                next_state   = DECODE;
            end
            DROP: begin
                if (!pkt_valid) next_state = DECODE;
            end
            default: next_state = DECODE;
        endcase

        // A timeout on the active port abandons the packet without touching the FIFO or err.
        if (abort) begin
            next_state   = DECODE;
            write        = 1'b0;
            lfd_state    = 1'b0;
            load_payload = 1'b0;
            load_parity  = 1'b0;
            load_hold    = 1'b0;
            check_parity = 1'b0;
        end
    end

endmodule

// File: rtl/router_ingress.sv
// Router ingress datapath: header/hold/parity registers and FIFO write muxing around the FSM.
module router_ingress
    import router_pkg::*;
#(
    parameter int DATA_W = 8
)
(
    input  logic                 clock,
    input  logic                 resetn,
    input  logic                 pkt_valid,
    input  logic [DATA_W-1:0]    data_in,
    input  logic [NUM_PORTS-1:0] fifo_full,
    input  logic [NUM_PORTS-1:0] fifo_empty,
    input  logic [NUM_PORTS-1:0] soft_reset,
    output logic                 busy,
    output logic [DATA_W-1:0]    dout,
    output logic [NUM_PORTS-1:0] write_en,
    output logic                 lfd_state,
    output logic                 err
);

    state_t             state;
    logic [LEN_LSB-1:0] addr;
    logic [LEN_MSB:0]   hdr;
    logic [DATA_W-1:0]  hold;
    logic [DATA_W-1:0]  run_par;
    logic [DATA_W-1:0]  rx_par;
    logic               hold_is_parity;
    logic               write;
    logic               load_hdr;
    logic               load_payload;
    logic               load_parity;
    logic               load_hold;
    logic               check_parity;

    router_ingress_fsm u_fsm (
        .clock          (clock),
        .resetn         (resetn),
        .pkt_valid      (pkt_valid),
        .hdr_addr       (data_in[LEN_LSB-1:0]),
        .addr           (addr),
        .fifo_full      (fifo_full),
        .fifo_empty     (fifo_empty),
        .soft_reset     (soft_reset),
        .hold_is_parity (hold_is_parity),
        .state          (state),
        .busy           (busy),
        .lfd_state      (lfd_state),
        .write          (write),
        .load_hdr       (load_hdr),
        .load_payload   (load_payload),
        .load_parity    (load_parity),
        .load_hold      (load_hold),
        .check_parity   (check_parity)
    );

    always_ff @(posedge clock) begin
        if (!resetn) begin
            addr           <= '0;
            hdr            <= '0;
            hold           <= '0;
            run_par        <= '0;
            rx_par         <= '0;
            hold_is_parity <= 1'b0;
            err            <= 1'b0;
        end else begin
            if (load_hdr) begin
                addr    <= data_in[LEN_LSB-1:0];
                hdr     <= data_in;
                run_par <= data_in;
                err     <= 1'b0;
            end
            if (load_payload) run_par <= run_par ^ data_in;
            if (load_parity)  rx_par  <= data_in;
            // A byte refused by a full FIFO is parked with a note of whether it closes the packet.
            if (load_hold) begin
                hold           <= data_in;
                hold_is_parity <= !pkt_valid;
            end
            if (check_parity) err <= (run_par != rx_par);
        end
    end

    always_comb begin
        dout = '0;
        case (state)
            LOAD_FIRST:      dout = hdr;
            LOAD_DATA:       dout = data_in;
            LOAD_AFTER_FULL: dout = hold;
            default:         dout = '0;
        endcase
    end

    assign write_en = write ? (NUM_PORTS'(1) << addr) : '0;

endmodule

// File: tb/tb_router_ingress.sv
// Directed bench for router_ingress: every FIFO write is matched against a per-packet byte queue.
`timescale 1ns/1ps
module tb_router_ingress;

    logic       clock;
    logic       resetn;
    logic       pkt_valid;
    logic [7:0] data_in;
    logic [2:0] fifo_full;
    logic [2:0] fifo_empty;
    logic [2:0] soft_reset;
    logic       busy;
    logic [7:0] dout;
    logic [2:0] write_en;
    logic       lfd_state;
    logic       err;

    typedef struct packed {
        logic [2:0] we;
        logic [7:0] d;
        logic       lfd;
    } wr_t;
    typedef logic [7:0] payload_t [4];

    wr_t  exp_q[$];
    logic exp_err;
    int   checks = 0;
    int   errors = 0;

    router_ingress #(.DATA_W(8)) dut (
        .clock      (clock),
        .resetn     (resetn),
        .pkt_valid  (pkt_valid),
        .data_in    (data_in),
        .fifo_full  (fifo_full),
        .fifo_empty (fifo_empty),
        .soft_reset (soft_reset),
        .busy       (busy),
        .dout       (dout),
        .write_en   (write_en),
        .lfd_state  (lfd_state),
        .err        (err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Model: a packet to a valid port is its header (marked), then every later byte, each written once in order.
    function automatic void expect_write(input logic [7:0] h, input logic [7:0] d, input logic lfd);
        wr_t e;
        e.we  = 3'b001 << h[1:0];
        e.d   = d;
        e.lfd = lfd;
        if (h[1:0] != 2'b11) exp_q.push_back(e);
    endfunction

    function automatic logic model_packet(input logic [7:0] h, input payload_t pl, input int n,
                                          input logic [7:0] par);
        logic [7:0] acc;
        acc = h;
        expect_write(h, h, 1'b1);
        for (int i = 0; i < n; i++) begin
            acc ^= pl[i];
            expect_write(h, pl[i], 1'b0);
        end
        expect_write(h, par, 1'b0);
        return acc != par;
    endfunction

    always @(negedge clock) begin
        wr_t e;
        if (resetn === 1'b1) begin
            if (write_en !== 3'b000) begin
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_write", 32'(write_en), 32'h0);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("mon_write_en", 32'(write_en), 32'(e.we));
                    checkOutput("mon_dout", 32'(dout), 32'(e.d));
                    checkOutput("mon_lfd", 32'(lfd_state), 32'(e.lfd));
                end
            end else begin
                checkOutput("mon_lfd_idle", 32'(lfd_state), 32'h0);
            end
        end
    end

    // Present one byte just after a rising edge and hold it until the DUT consumes it.
    task automatic applyStimulus(input logic v, input logic [7:0] d, output int stalls);
        pkt_valid = v;
        data_in   = d;
        stalls    = 0;
        @(negedge clock);
        while (busy === 1'b1 && stalls < 50) begin
            stalls++;
            @(negedge clock);
        end
        if (busy !== 1'b0) checkOutput("handshake_timeout", 32'(busy), 32'h0);
        @(posedge clock);
        #1;
    endtask

    task automatic finish_packet(input string name, input logic e);
        int n;
        n = 0;
        @(negedge clock);
        while (busy === 1'b1 && n < 20) begin
            n++;
            @(negedge clock);
        end
        checkOutput({name, "_idle"}, 32'(busy), 32'h0);
        checkOutput({name, "_err"}, 32'(err), 32'(e));
        checkOutput({name, "_drained"}, 32'(exp_q.size()), 32'h0);
        @(posedge clock);
        #1;
    endtask

    task automatic send_packet(input string name, input logic [7:0] h, input payload_t pl, input int n,
                               input logic [7:0] par, input logic full_on_par);
        int st;
        exp_err = model_packet(h, pl, n, par);
        applyStimulus(1'b1, h, st);
        for (int i = 0; i < n; i++) applyStimulus(1'b1, pl[i], st);
        if (full_on_par) fifo_full = 3'b001 << h[1:0];
        applyStimulus(1'b0, par, st);
        if (full_on_par) begin
            checkOutput({name, "_par_held"}, 32'(write_en), 32'h0);
            checkOutput({name, "_par_busy"}, 32'(busy), 32'h1);
            @(posedge clock);
            #1;
            fifo_full = 3'b000;
        end
        finish_packet(name, exp_err);
    endtask

    task automatic check_reset_outputs(input string name);
        checkOutput({name, "_busy"}, 32'(busy), 32'h0);
        checkOutput({name, "_write_en"}, 32'(write_en), 32'h0);
        checkOutput({name, "_lfd"}, 32'(lfd_state), 32'h0);
        checkOutput({name, "_err"}, 32'(err), 32'h0);
        checkOutput({name, "_dout"}, 32'(dout), 32'h0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int st;
        resetn     = 1'b0;
        pkt_valid  = 1'b0;
        data_in    = 8'h00;
        fifo_full  = 3'b000;
        fifo_empty = 3'b111;
        soft_reset = 3'b000;
        repeat (2) @(posedge clock);
        #1;
        resetn = 1'b1;
        check_reset_outputs("por");

        // Good packet to port 1 with literal pins on header timing and the result.
        exp_err = model_packet(8'h0D, '{8'h11, 8'h22, 8'h33, 8'h00}, 3, 8'h0D);
        applyStimulus(1'b1, 8'h0D, st);
        checkOutput("t1_hdr_we", 32'(write_en), 32'h2);
        checkOutput("t1_hdr_dout", 32'(dout), 32'h0D);
        checkOutput("t1_hdr_lfd", 32'(lfd_state), 32'h1);
        checkOutput("t1_hdr_busy", 32'(busy), 32'h1);
        applyStimulus(1'b1, 8'h11, st);
        checkOutput("t1_first_payload_stall", 32'(st), 32'd1);
        applyStimulus(1'b1, 8'h22, st);
        checkOutput("t1_payload_stall", 32'(st), 32'd0);
        applyStimulus(1'b1, 8'h33, st);
        applyStimulus(1'b0, 8'h0D, st);
        checkOutput("t1_check_busy", 32'(busy), 32'h1);
        finish_packet("t1", exp_err);
        checkOutput("t1_err_literal", 32'(err), 32'h0);

        // Bad parity, err held until the next header.
        send_packet("t2", 8'h0D, '{8'h11, 8'h22, 8'h33, 8'h00}, 3, 8'h00, 1'b0);
        for (int i = 0; i < 3; i++) begin
            checkOutput("t2_err_held", 32'(err), 32'h1);
            @(posedge clock);
            #1;
        end

        // Port 1 full for three cycles starting with the second payload byte.
        exp_err = model_packet(8'h0D, '{8'h11, 8'h22, 8'h33, 8'h00}, 3, 8'h0D);
        applyStimulus(1'b1, 8'h0D, st);
        checkOutput("t3_err_cleared", 32'(err), 32'h0);
        applyStimulus(1'b1, 8'h11, st);
        fifo_full = 3'b010;
        applyStimulus(1'b1, 8'h22, st);
        checkOutput("t3_hold_busy", 32'(busy), 32'h1);
        checkOutput("t3_hold_no_write", 32'(write_en), 32'h0);
        @(posedge clock);
        #1;
        @(posedge clock);
        #1;
        fifo_full = 3'b000;
        applyStimulus(1'b1, 8'h33, st);
        checkOutput("t3_resume_stall", 32'(st), 32'd2);
        applyStimulus(1'b0, 8'h0D, st);
        finish_packet("t3", exp_err);

        // Full arriving with the parity byte, good and bad parity.
        send_packet("t4a", 8'h0A, '{8'h5A, 8'hA5, 8'h00, 8'h00}, 2, 8'hF5, 1'b1);
        checkOutput("t4a_err_literal", 32'(err), 32'h0);
        send_packet("t4b", 8'h0A, '{8'h5A, 8'hA5, 8'h00, 8'h00}, 2, 8'h00, 1'b1);
        checkOutput("t4b_err_literal", 32'(err), 32'h1);

        // Reset while idle with err set.
        resetn = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        resetn = 1'b1;
        check_reset_outputs("idle_rst");

        // Address 3 is swallowed without stalling.
        applyStimulus(1'b1, 8'h07, st);
        checkOutput("t6_hdr_stall", 32'(st), 32'd0);
        applyStimulus(1'b1, 8'hAA, st);
        checkOutput("t6_pay_stall", 32'(st), 32'd0);
        applyStimulus(1'b0, 8'hBB, st);
        checkOutput("t6_par_stall", 32'(st), 32'd0);

        // Next header lands in DECODE and waits four cycles for port 0 to drain.
        exp_err    = model_packet(8'h04, '{8'h77, 8'h00, 8'h00, 8'h00}, 1, 8'h73);
        fifo_empty = 3'b110;
        applyStimulus(1'b1, 8'h04, st);
        for (int i = 0; i < 3; i++) begin
            checkOutput("t7_wait_busy", 32'(busy), 32'h1);
            checkOutput("t7_wait_no_write", 32'(write_en), 32'h0);
            @(posedge clock);
            #1;
        end
        fifo_empty = 3'b111;
        checkOutput("t7_wait_busy_last", 32'(busy), 32'h1);
        @(posedge clock);
        #1;
        checkOutput("t7_hdr_we", 32'(write_en), 32'h1);
        checkOutput("t7_hdr_lfd", 32'(lfd_state), 32'h1);
        applyStimulus(1'b1, 8'h77, st);
        checkOutput("t7_payload_stall", 32'(st), 32'd1);
        applyStimulus(1'b0, 8'h73, st);
        finish_packet("t7", exp_err);

        // Soft reset mid-payload; the aborted tail is never written.
        expect_write(8'h0D, 8'h0D, 1'b1);
        expect_write(8'h0D, 8'h11, 1'b0);
        applyStimulus(1'b1, 8'h0D, st);
        applyStimulus(1'b1, 8'h11, st);
        soft_reset = 3'b010;
        data_in    = 8'h22;
        @(negedge clock);
        checkOutput("t8_sr_no_write", 32'(write_en), 32'h0);
        @(posedge clock);
        #1;
        soft_reset = 3'b000;
        pkt_valid  = 1'b0;
        checkOutput("t8_sr_busy", 32'(busy), 32'h0);
        checkOutput("t8_sr_err", 32'(err), 32'h0);
        checkOutput("t8_sr_drained", 32'(exp_q.size()), 32'h0);
        send_packet("t8_next", 8'h08, '{8'h01, 8'h02, 8'h00, 8'h00}, 2, 8'h0B, 1'b0);

        // Soft reset during the parity check leaves err untouched.
        exp_err = model_packet(8'h0D, '{8'h11, 8'h22, 8'h33, 8'h00}, 3, 8'h00);
        applyStimulus(1'b1, 8'h0D, st);
        applyStimulus(1'b1, 8'h11, st);
        applyStimulus(1'b1, 8'h22, st);
        applyStimulus(1'b1, 8'h33, st);
        applyStimulus(1'b0, 8'h00, st);
        soft_reset = 3'b010;
        @(posedge clock);
        #1;
        soft_reset = 3'b000;
        checkOutput("t9_err_kept", 32'(err), 32'h0);
        checkOutput("t9_busy", 32'(busy), 32'h0);
        checkOutput("t9_drained", 32'(exp_q.size()), 32'h0);

        // resetn mid-packet, then a normal packet.
        applyStimulus(1'b1, 8'h0D, st);
        resetn    = 1'b0;
        pkt_valid = 1'b0;
        data_in   = 8'h00;
        repeat (2) @(posedge clock);
        #1;
        resetn = 1'b1;
        check_reset_outputs("mid_rst");
        send_packet("t10", 8'h05, '{8'h3C, 8'h00, 8'h00, 8'h00}, 1, 8'h39, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/router_ingress.md
# router_ingress

Packet ingress stage of the 1x3 router, directly upstream of the three output FIFOs. It accepts byte-serial packets from the source (header, payload, parity) and decodes the 2-bit destination address. It drives the selected FIFO's write strobe, data byte and header-marker bit, stalls the source with `busy` while the destination is occupied or full, and checks end-of-packet parity.

## Interface
- `DATA_W`, default 8: byte width. Only 8 is supported; the header layout depends on it.

- `clock`  in  1  system clock, all state on the rising edge
- `resetn`  in  1  reset, synchronous, active-low
- `pkt_valid`  in  1  high from the header through the last payload byte; low on the parity byte
- `data_in`  in  8  source byte
- `fifo_full`  in  3  per-port FIFO full flags
- `fifo_empty`  in  3  per-port FIFO empty flags
- `soft_reset`  in  3  per-port timeout resets from the synchronizer
- `busy`  out  1  source must hold `data_in`/`pkt_valid` while high
- `dout`  out  8  byte to the FIFO `data_in`
- `write_en`  out  3  one-hot FIFO write strobe, at most one bit set
- `lfd_state`  out  1  high only on the header write
- `err`  out  1  parity mismatch on the last packet

## Operation
- Header byte: `[7:2]` = payload length (0..63), `[1:0]` = address. Address 3 is invalid.
- States: DECODE, WAIT_EMPTY, LOAD_FIRST, LOAD_DATA, FULL_HOLD, LOAD_AFTER_FULL, CHECK_PARITY, DROP.
- **DECODE** (busy 0)
  - On `pkt_valid`: latch `addr` and `hdr`, clear `err`, set running parity to the header.
  - Address 3 -> DROP.
  - Else if `fifo_empty[addr]` -> LOAD_FIRST, otherwise -> WAIT_EMPTY.
- **WAIT_EMPTY** (busy 1): -> LOAD_FIRST once `fifo_empty[addr]` is high.
- **LOAD_FIRST** (busy 1)
  - `dout`=`hdr`, `write_en[addr]`=1, `lfd_state`=1.
  - -> LOAD_DATA.
- **LOAD_DATA** (busy 0)
  - `dout`=`data_in`; `write_en[addr]` = !`fifo_full[addr]`.
  - When `pkt_valid`=1 the byte is payload and is XORed into the running parity.
  - When `pkt_valid`=0 the byte is parity: capture it as `rx_par`, -> CHECK_PARITY.
  - If `fifo_full[addr]`: copy the byte into `hold`, record a parity/payload flag, -> FULL_HOLD. A payload byte is still XORed.
- **FULL_HOLD** (busy 1, no write): -> LOAD_AFTER_FULL once `fifo_full[addr]` is low.
- **LOAD_AFTER_FULL** (busy 1)
  - `dout`=`hold`, `write_en[addr]`=1.
  - -> CHECK_PARITY if the held byte was parity, else -> LOAD_DATA.
- **CHECK_PARITY** (busy 1): `err` <= (running parity != `rx_par`); -> DECODE.
- **DROP** (busy 0, no writes): -> DECODE on the cycle `pkt_valid` is low.
- Parity bytes are written to the FIFO; the FIFO's length+1 count covers them.
- `soft_reset[addr]` high in any state other than DECODE/DROP: `write_en` is 0 that cycle, -> DECODE next cycle, `err` is not updated. Only `resetn` has higher priority.
- Reset values: state DECODE, `busy` 0, `write_en` 0, `lfd_state` 0, `err` 0, `dout` 0, all internal registers 0.
- `dout`, `write_en`, `lfd_state` and `busy` are combinational from the state and registers. `err` is registered.

## Timing
- Source handshake: a byte is consumed at a rising edge only when `busy`=0 in that cycle. While `busy`=1 the source holds its byte.
- Header latency: header presented in cycle 0 (DECODE), written in cycle 1 with an empty FIFO. The first payload byte is held through cycle 1 and written in cycle 2.
- Payload and parity bytes are written in the cycle they are presented, when not full.
- `err` is valid the cycle after CHECK_PARITY. It stays held until the next header is accepted.
- Full raised together with the parity byte: the parity byte is held and written exactly once.
- `fifo_full` is sampled in the write cycle. No byte is ever written twice or lost.
- Minimum packet with length 1: 5 cycles from header to return to DECODE.

## Structure
- `router_pkg` holds:
  - the state enum
  - `NUM_PORTS`=3, `ADDR_INVALID`=2'b11
  - the header field positions `LEN_MSB`=7, `LEN_LSB`=2
- Sub-module `router_ingress_fsm`: state register, next-state logic, and decoded `busy`/`lfd_state`/load strobes.
- The top level keeps the datapath: `addr`, `hdr`, `hold`, running parity, `rx_par`, `err`, and the `dout`/`write_en` muxing.

## Test plan
- Reset: hold `resetn` low for 2 cycles mid-packet -> DECODE; `busy` 0, `write_en` 000, `lfd_state` 0, `err` 0.
- Good packet: header 8'h0D, payload 11/22/33, parity 8'h0D, all FIFOs empty -> five writes with `write_en`=010, `lfd_state` high only on the header write, `err`=0.
- Bad parity: same packet with parity 8'h00 -> the same five writes, then `err`=1 from the cycle after CHECK_PARITY until the next header is accepted.
- Backpressure:
  - `fifo_full[1]` raised for 3 cycles during the second payload byte -> `busy` high, the byte is written once in LOAD_AFTER_FULL, the write order is preserved, `err`=0.
  - Full coincident with the parity byte -> the parity byte is written once and is checked correctly.
- Invalid and blocked destinations:
  - Header 8'h07 (address 3) -> no `write_en`, `busy` 0, back in DECODE the cycle after `pkt_valid` falls.
  - Header 8'h04 with `fifo_empty[0]`=0 for 4 cycles -> WAIT_EMPTY with `busy` high for 4 cycles, header written on the 5th.
- Soft reset: pulse `soft_reset[1]` mid-payload -> `write_en` 0 that cycle, DECODE next cycle, `err` unchanged, the following packet is processed normally.
